// File: rtl/sdram_wr_pkg.sv
// Shared state type and default geometry for the SDRAM burst writer.
package sdram_wr_pkg;

    localparam int unsigned DEF_BURST_LEN = 256;
    localparam int unsigned DEF_ADDR_W    = 22;
    localparam int unsigned PIX_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head word is visible on dout whenever not empty.
module sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Zero while empty so the output is clean straight out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_burst_writer.sv
// Buffers upstream pixels and writes them to SDRAM as fixed-length bursts, one frame at a time.
// Define SDRAM_WR_DBLBUF_EN to alternate between two frame buffers at each frame end.
module sdram_burst_writer
    import sdram_wr_pkg::*;
#(
    parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned       FRAME_WORDS = 1024 * 768,
    parameter int unsigned       FIFO_DEPTH  = 512,
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    output logic              wr_en_o,
    input  logic              data_en_i,
    input  logic [PIX_W-1:0]  din,
    output logic              wr_req_o,
    input  logic              wr_ack_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              wr_data_req_i,
    output logic [PIX_W-1:0]  wr_data_o,
    output logic              frame_done_o,
    output logic              buf_sel_o,
    output logic              overflow_o
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FCNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

    wr_state_t         state;
    logic [FCNT_W-1:0] frame_cnt;
    logic [BCNT_W-1:0] beat_cnt;
    logic              pending;
    logic              pop_req;
    logic              popped;
    logic              last_burst;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W-1:0] end_base;

    sync_fifo #(
        .DATA_W (PIX_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_en_i),
        .din   (din),
        .pop   (pop_req),
        .dout  (wr_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Controller pops are only honoured inside a burst.
    assign pop_req    = (state == ST_XFER) && wr_data_req_i;
    assign popped     = pop_req && !fifo_empty;
    assign last_burst = (frame_cnt == FCNT_W'(FRAME_WORDS - BURST_LEN));

`ifdef SDRAM_WR_DBLBUF_EN
    localparam logic [ADDR_W-1:0] ALT_BASE = ADDR_W'(BASE_ADDR + FRAME_WORDS);

    logic buf_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel_q <= 1'b0;
        end else if ((state == ST_DONE) && frame_done_o) begin
            buf_sel_q <= ~buf_sel_q;
        end
    end

    assign buf_sel_o = buf_sel_q;
    assign cur_base  = buf_sel_q ? ALT_BASE : BASE_ADDR;
    // Base of the buffer selected once the current frame ends.
    assign end_base  = buf_sel_q ? BASE_ADDR : ALT_BASE;
`else
    assign buf_sel_o = 1'b0;
    assign cur_base  = BASE_ADDR;
    assign end_base  = BASE_ADDR;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            frame_cnt    <= '0;
            beat_cnt     <= '0;
            pending      <= 1'b0;
            wr_addr_o    <= BASE_ADDR;
            wr_en_o      <= 1'b0;
            wr_req_o     <= 1'b0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            // Threshold leaves headroom for the upstream one-cycle response latency.
            wr_en_o      <= (fifo_count <= CNT_W'(FIFO_DEPTH - 4));
            if (data_en_i && fifo_full) begin
                overflow_o <= 1'b1;
            end
            if (frame_start_i && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        frame_cnt <= '0;
                        wr_addr_o <= cur_base;
                    end
                    if (fifo_count >= CNT_W'(BURST_LEN)) begin
                        state    <= ST_REQ;
                        wr_req_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (wr_ack_i) begin
                        state    <= ST_XFER;
                        wr_req_o <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (popped) begin
                        beat_cnt <= beat_cnt + BCNT_W'(1);
                        if (beat_cnt == BCNT_W'(BURST_LEN - 1)) begin
                            state        <= ST_DONE;
                            frame_done_o <= last_burst;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                    if (frame_done_o) begin
                        frame_cnt <= '0;
                        wr_addr_o <= end_base;
                    end else if (pending || frame_start_i) begin
                        frame_cnt <= '0;
                        wr_addr_o <= cur_base;
                    end else begin
                        frame_cnt <= frame_cnt + FCNT_W'(BURST_LEN);
                        wr_addr_o <= wr_addr_o + ADDR_W'(BURST_LEN);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer: bursts, frame wrap, FIFO fill, overflow, frame restart, reset.
`timescale 1ns/1ps
module tb_sdram_burst_writer;

    localparam int unsigned BL    = 256;
    localparam int unsigned FW    = 1024;
    localparam int unsigned DEPTH = 512;

`ifdef SDRAM_WR_DBLBUF_EN
    localparam logic [21:0] END_BASE = 22'd1024;
    localparam logic        END_SEL  = 1'b1;
`else
    localparam logic [21:0] END_BASE = 22'd0;
    localparam logic        END_SEL  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start_i;
    logic        wr_en_o;
    logic        data_en_i;
    logic [15:0] din;
    logic        wr_req_o;
    logic        wr_ack_i;
    logic [21:0] wr_addr_o;
    logic        wr_data_req_i;
    logic [15:0] wr_data_o;
    logic        frame_done_o;
    logic        buf_sel_o;
    logic        overflow_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] model_q[$];
    logic [15:0] pix;

    always #5 clk = ~clk;

    sdram_burst_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (22),
        .BASE_ADDR   (22'd0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .wr_en_o       (wr_en_o),
        .data_en_i     (data_en_i),
        .din           (din),
        .wr_req_o      (wr_req_o),
        .wr_ack_i      (wr_ack_i),
        .wr_addr_o     (wr_addr_o),
        .wr_data_req_i (wr_data_req_i),
        .wr_data_o     (wr_data_o),
        .frame_done_o  (frame_done_o),
        .buf_sel_o     (buf_sel_o),
        .overflow_o    (overflow_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        frame_start_i = 1'b0;
        data_en_i     = 1'b0;
        din           = '0;
        wr_ack_i      = 1'b0;
        wr_data_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_q.delete();
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            data_en_i = 1'b1;
            din       = pix;
            model_q.push_back(pix);
            pix++;
            tick();
        end
        data_en_i = 1'b0;
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (wr_req_o !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        vectors++;
        if (wr_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_req: wr_req_o=%b after %0d cycles, required 1", wr_req_o, n);
        end
    endtask

    task automatic do_burst(input logic [21:0] exp_addr, input logic exp_done,
                            input logic [21:0] next_addr, input int fs_at);
        logic [15:0] exp_w;
        wait_req(20);
        vectors++;
        if (wr_addr_o !== exp_addr) begin
            miscompares++;
            $display("FAIL burst_addr: wr_addr_o=%0d required %0d", wr_addr_o, exp_addr);
        end
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        vectors++;
        if (wr_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL req_after_ack: wr_req_o=%b required 0", wr_req_o);
        end
        for (int i = 0; i < BL; i++) begin
            wr_data_req_i = 1'b1;
            frame_start_i = (i == fs_at);
            exp_w = (model_q.size() != 0) ? model_q.pop_front() : 16'hdead;
            vectors++;
            if (wr_data_o !== exp_w) begin
                miscompares++;
                $display("FAIL burst_data[%0d]: wr_data_o=%h required %h", i, wr_data_o, exp_w);
            end
            tick();
        end
        wr_data_req_i = 1'b0;
        frame_start_i = 1'b0;
        vectors++;
        if (frame_done_o !== exp_done) begin
            miscompares++;
            $display("FAIL frame_done_in_done: frame_done_o=%b required %b", frame_done_o, exp_done);
        end
        tick();
        vectors++;
        if (frame_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_pulse: frame_done_o=%b required 0", frame_done_o);
        end
        vectors++;
        if (wr_addr_o !== next_addr) begin
            miscompares++;
            $display("FAIL next_addr: wr_addr_o=%0d required %0d", wr_addr_o, next_addr);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({wr_en_o, wr_req_o, frame_done_o, overflow_o, buf_sel_o} !== 5'b00000) begin
            miscompares++;
            $display("FAIL %s_flags: en/req/done/ovf/sel=%b required 00000", tag,
                     {wr_en_o, wr_req_o, frame_done_o, overflow_o, buf_sel_o});
        end
        vectors++;
        if (wr_data_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s_data: wr_data_o=%h required 0000", tag, wr_data_o);
        end
        vectors++;
        if (wr_addr_o !== 22'd0) begin
            miscompares++;
            $display("FAIL %s_addr: wr_addr_o=%0d required 0", tag, wr_addr_o);
        end
        vectors++;
        if (int'(u_dut.fifo_count) !== 0) begin
            miscompares++;
            $display("FAIL %s_count: count=%0d required 0", tag, u_dut.fifo_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        push_words(10);
        rst = 1'b1;
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        vectors++;
        if (wr_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_wr_en: wr_en_o=%b required 1", wr_en_o);
        end
        model_q.delete();
    endtask

    task automatic test_first_burst();
        do_reset();
        push_words(BL - 1);
        tick();
        vectors++;
        if (wr_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL req_below_burst: wr_req_o=%b required 0", wr_req_o);
        end
        push_words(1);
        tick();
        vectors++;
        if (wr_req_o !== 1'b1 || wr_addr_o !== 22'd0) begin
            miscompares++;
            $display("FAIL req_at_burst: req=%b addr=%0d required 1/0", wr_req_o, wr_addr_o);
        end
        wr_data_req_i = 1'b1;
        tick();
        wr_data_req_i = 1'b0;
        vectors++;
        if (int'(u_dut.fifo_count) !== 256 || wr_data_o !== model_q[0] || wr_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pop_outside_xfer: count=%0d head=%h req=%b required 256/%h/1",
                     u_dut.fifo_count, wr_data_o, wr_req_o, model_q[0]);
        end
        do_burst(22'd0, 1'b0, 22'd256, -1);
        vectors++;
        if (wr_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL req_after_burst: wr_req_o=%b required 0", wr_req_o);
        end
    endtask

    task automatic test_frame();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push_words(BL);
            do_burst(22'(b * BL), (b == 3), (b == 3) ? END_BASE : 22'((b + 1) * BL), -1);
        end
        vectors++;
        if (buf_sel_o !== END_SEL) begin
            miscompares++;
            $display("FAIL frame_buf_sel: buf_sel_o=%b required %b", buf_sel_o, END_SEL);
        end
        push_words(BL);
        do_burst(END_BASE, 1'b0, END_BASE + 22'd256, -1);
    endtask

    task automatic test_fill();
        logic prev_en = 1'b0;
        logic seen_low = 1'b0;
        int   low_cycles = 0;
        int   n = 0;
        do_reset();
        while (low_cycles < 6 && n < 2000) begin
            if (!wr_en_o && !seen_low) begin
                seen_low = 1'b1;
                vectors++;
                if (int'(u_dut.fifo_count) !== 510) begin
                    miscompares++;
                    $display("FAIL fill_wr_en_drop: count=%0d at first wr_en_o=0, required 510",
                             u_dut.fifo_count);
                end
            end
            low_cycles = wr_en_o ? 0 : low_cycles + 1;
            data_en_i  = prev_en;
            din        = pix;
            pix++;
            prev_en    = wr_en_o;
            tick();
            n++;
        end
        data_en_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (seen_low !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_timeout: wr_en_o never dropped within %0d cycles", n);
        end
        vectors++;
        if (int'(u_dut.fifo_count) !== 511 || overflow_o !== 1'b0 || wr_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_final: count=%0d ovf=%b wr_en=%b required 511/0/0",
                     u_dut.fifo_count, overflow_o, wr_en_o);
        end
        vectors++;
        if (wr_req_o !== 1'b1 || wr_addr_o !== 22'd0) begin
            miscompares++;
            $display("FAIL fill_req: req=%b addr=%0d required 1/0", wr_req_o, wr_addr_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push_words(DEPTH);
        vectors++;
        if (overflow_o !== 1'b0 || int'(u_dut.fifo_count) !== 512) begin
            miscompares++;
            $display("FAIL ovf_at_full: ovf=%b count=%0d required 0/512", overflow_o, u_dut.fifo_count);
        end
        data_en_i = 1'b1;
        din       = 16'hbeef;
        tick();
        data_en_i = 1'b0;
        vectors++;
        if (overflow_o !== 1'b1 || int'(u_dut.fifo_count) !== 512) begin
            miscompares++;
            $display("FAIL ovf_set: ovf=%b count=%0d required 1/512", overflow_o, u_dut.fifo_count);
        end
        tick();
        tick();
        tick();
        do_burst(22'd0, 1'b0, 22'd256, -1);
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: overflow_o=%b required 1", overflow_o);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_cleared: overflow_o=%b required 0", overflow_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_frame_start();
        do_reset();
        push_words(BL);
        do_burst(22'd0, 1'b0, 22'd256, -1);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        vectors++;
        if (wr_addr_o !== 22'd0) begin
            miscompares++;
            $display("FAIL fs_idle_reload: wr_addr_o=%0d required 0", wr_addr_o);
        end
        push_words(2 * BL);
        do_burst(22'd0, 1'b0, 22'd256, -1);
        do_burst(22'd256, 1'b0, 22'd0, 100);
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        push_words(300);
        wait_req(20);
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            wr_data_req_i = 1'b1;
            data_en_i     = 1'b1;
            din           = pix;
            pix++;
            tick();
        end
        data_en_i = 1'b0;
        vectors++;
        if (int'(u_dut.fifo_count) !== 300) begin
            miscompares++;
            $display("FAIL push_pop_same_cycle: count=%0d required 300", u_dut.fifo_count);
        end
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_xfer_reset");
        rst           = 1'b0;
        wr_data_req_i = 1'b0;
        tick();
        vectors++;
        if (wr_req_o !== 1'b0 || wr_en_o !== 1'b1 || int'(u_dut.fifo_count) !== 0) begin
            miscompares++;
            $display("FAIL after_mid_reset: req=%b wr_en=%b count=%0d required 0/1/0",
                     wr_req_o, wr_en_o, u_dut.fifo_count);
        end
    endtask

    initial begin
        pix = 16'h1000;
        test_reset();
        test_first_burst();
        test_frame();
        test_fill();
        test_overflow();
        test_frame_start();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
